fetch_predict_unit: RTL and testbench
=====================================

Name: fetch_predict_unit

Overview:
Parametrised next-generation fetch stage for the pipelined core. It holds the program counter and presents the instruction-memory address. It predicts taken branches and jumps with a direct-mapped branch target buffer (BTB) that carries 2-bit saturating counters. It also registers the fetch/decode pipeline latch, including noop injection on redirect. This replaces the fixed "always PC+1, flush on resolve" fetch, so correctly predicted taken branches lose no cycles.

Parameters:
ADDR_W, 32, PC/target width; the PC is word-addressed and increments by 1
INSN_W, 32, instruction width; the noop encoding is all-zero
IMEM_ADDR_W, 12, width of the imem address output (low PC bits)
BTB_ENTRIES, 16, BTB depth; power of 2, at least 2
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold the PC and the fd latch (load-use hazard)
imem_addr  out  IMEM_ADDR_W  pc[IMEM_ADDR_W-1:0], combinational from the PC register
imem_data  in  INSN_W  instruction at imem_addr, valid before the next rising edge
redirect_valid  in  1  the resolving stage found a mispredict or jr
redirect_pc  in  ADDR_W  correct next PC
upd_valid  in  1  BTB training strobe for a resolved control instruction
upd_pc  in  ADDR_W  PC of the resolved instruction
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual target
fd_pc  out  ADDR_W  PC of the latched instruction, plus 1
fd_ir  out  INSN_W  latched instruction
fd_pred_taken  out  1  the prediction made for fd_ir
fd_pred_target  out  ADDR_W  predicted next PC for fd_ir

Behaviour:
- Reset (synchronous, top priority):
  - pc = RESET_PC.
  - fd_ir = 0 and fd_pc = RESET_PC.
  - fd_pred_taken = 0 and fd_pred_target = 0.
  - All BTB valid bits cleared.
  - All counters = 2'b01 (weakly not-taken).
- BTB indexing: index = pc[log2(BTB_ENTRIES)-1:0]. The tag is the remaining ADDR_W−log2(BTB_ENTRIES) bits.
- Lookup (combinational on the current pc):
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - next_pc = pred_taken ? btb_target : pc+1. The adder wraps modulo 2^ADDR_W.
- PC update priority per edge: reset > redirect_valid > stall > predict.
  - redirect_valid: pc = redirect_pc. This applies even when stall is high.
  - stall alone: pc holds.
  - Otherwise: pc = next_pc.
- fd latch update, same priority order:
  - redirect_valid: fd_ir = 0 (noop); fd_pred_taken = 0; fd_pc and fd_pred_target don't care, but driven to 0.
  - stall: all fd outputs hold.
  - Otherwise: fd_ir = imem_data, fd_pc = pc+1, fd_pred_taken = pred_taken, fd_pred_target = next_pc.
- Latency: an instruction whose address is presented in cycle n appears on fd_* after edge n+1. A redirect costs exactly one noop bubble from this block.
- Training, on upd_valid (independent of stall and redirect; suppressed by reset):
  - Hit: ctr saturates up if taken, down if not taken (00 and 11 are sticky). The target is overwritten with upd_target when taken.
  - Miss and taken: allocate the entry with valid = 1, the new tag, target = upd_target, ctr = 2'b10.
  - Miss and not taken: no change.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents (read-before-write).
- Reset asserted mid-stall or mid-redirect: the reset values win and no training occurs that cycle.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds outputs perf_fetched, perf_redirects and perf_btb_hits, each 32 bits.
  - They count non-stalled fetches, redirect_valid cycles, and hits whose lookup drove next_pc, respectively.
  - Counters saturate at all-ones and clear on reset.
- Undefined: these ports and their counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - NOOP_INSN = 0
  - the counter encodings SNT = 00, WNT = 01, WT = 10, ST = 11
  - the counter saturate-increment and saturate-decrement functions
  - the index/tag width helper
- One natural sub-module, btb_table, holds the valid, tag, target and counter arrays. It has one combinational read port and one synchronous write port, and it is reset-clearable.
- The PC register and the fd latch stay in the top level.

Test Plan:
1. Reset, then 4 unstalled cycles with imem_data = 0xA0+addr. Required: imem_addr goes 0,1,2,3. fd_pc goes 1,2,3,4. fd_pred_taken stays 0.
2. upd_valid with upd_pc=5, taken, target=0x40 (BTB_ENTRIES=16). Then run sequential fetch from pc=0. Required: the cycle after pc=5, pc = 0x40 and fd_pred_target = 0x40.
3. With stall and redirect_valid high together, redirect_pc=0x100. Required: on the next edge pc = 0x100 and fd_ir = 0. With stall alone, pc and fd_* hold for 3 cycles.
4. Train pc=5 taken, then not-taken twice. Required: the counter goes 10→01→00. The next fetch of 5 predicts not-taken (next pc 6). Further not-taken updates keep 00.
5. Alias test: train pc=5, then fetch pc=0x15. Same index, different tag, so required: miss and next pc 0x16. Then train 0x15 taken to 0x80. Required: the entry is replaced, and fetch of pc 5 now misses.
6. Wrap: redirect_pc = 0xFFFFFFFF with the BTB missing. Required: the next pc is 0x00000000 and fd_pc = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types, constants and helpers for the fetch/predict unit.
//             It holds the noop encoding, the 2-bit counter states, the
//             saturating counter functions and the BTB index/tag widths.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // The noop instruction is the all-zero word.
  localparam int NOOP_INSN = 0;

  // 2-bit direction counter. Bit 1 set means "predict taken".
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Saturating increment: a counter at ST stays at ST.
  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  // Saturating decrement: a counter at SNT stays at SNT.
  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

  // Number of PC bits that index the BTB.
  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Number of PC bits kept as the tag.
  function automatic int btb_tag_w(input int addr_w, input int entries);
    return addr_w - $clog2(entries);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_table.sv
// ============================================================================
//  Module   : btb_table
//  Purpose  : Direct-mapped branch target buffer. It has one combinational
//             lookup port and one synchronous training port. Reset clears
//             every valid bit and sets every counter to weakly not-taken.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_table
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_pc,
  output logic              rd_pred_taken,
  output logic [ADDR_W-1:0] rd_target,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic              wr_taken,
  input  logic [ADDR_W-1:0] wr_target
);

  localparam int IDX_W = btb_idx_w(ENTRIES);
  localparam int TAG_W = btb_tag_w(ADDR_W, ENTRIES);

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  ctr_t              r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_rd_hit;
  logic             w_wr_hit;

  assign w_rd_idx = rd_pc[IDX_W-1:0];
  assign w_rd_tag = rd_pc[ADDR_W-1:IDX_W];
  assign w_wr_idx = wr_pc[IDX_W-1:0];
  assign w_wr_tag = wr_pc[ADDR_W-1:IDX_W];

  // The lookup reads the stored arrays, so it always sees pre-update contents.
  assign w_rd_hit      = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign rd_pred_taken = w_rd_hit && r_ctr[w_rd_idx][1];
  assign rd_target     = r_target[w_rd_idx];

  assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

  // Training: on a hit, move the counter (and retarget when taken). On a miss, allocate only when taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= WNT;
      end
    end else if (wr_valid) begin
      if (w_wr_hit) begin
        if (wr_taken) begin
          r_ctr[w_wr_idx]    <= ctr_inc(r_ctr[w_wr_idx]);
          r_target[w_wr_idx] <= wr_target;
        end else begin
          r_ctr[w_wr_idx] <= ctr_dec(r_ctr[w_wr_idx]);
        end
      end else if (wr_taken) begin
        r_valid[w_wr_idx]  <= 1'b1;
        r_tag[w_wr_idx]    <= w_wr_tag;
        r_target[w_wr_idx] <= wr_target;
        r_ctr[w_wr_idx]    <= WT;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_predict_unit.sv
// ============================================================================
//  Module   : fetch_predict_unit
//  Purpose  : Fetch stage. It holds the PC, predicts the next PC from a BTB
//             and registers the fetch/decode latch. A redirect replaces the
//             latched instruction with a noop.
//  Options  : FETCH_PERF_EN adds saturating 32-bit performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_predict_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                INSN_W      = 32,
  parameter int                IMEM_ADDR_W = 12,
  parameter int                BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0]      imem_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   upd_valid,
  input  logic [ADDR_W-1:0]      upd_pc,
  input  logic                   upd_taken,
  input  logic [ADDR_W-1:0]      upd_target,
  output logic [ADDR_W-1:0]      fd_pc,
  output logic [INSN_W-1:0]      fd_ir,
  output logic                   fd_pred_taken,
  output logic [ADDR_W-1:0]      fd_pred_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_redirects,
  output logic [31:0]            perf_btb_hits
`endif
);

  localparam logic [INSN_W-1:0] c_noop = INSN_W'(NOOP_INSN);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fd_pc;
  logic [INSN_W-1:0] r_fd_ir;
  logic              r_fd_pred_taken;
  logic [ADDR_W-1:0] r_fd_pred_target;

  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_btb_target;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_next_pc;

  btb_table #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clock         (clock),
    .reset         (reset),
    .rd_pc         (r_pc),
    .rd_pred_taken (w_pred_taken),
    .rd_target     (w_btb_target),
    .wr_valid      (upd_valid),
    .wr_pc         (upd_pc),
    .wr_taken      (upd_taken),
    .wr_target     (upd_target)
  );

  assign w_pc_plus1 = r_pc + ADDR_W'(1);
  assign w_next_pc  = w_pred_taken ? w_btb_target : w_pc_plus1;
  assign imem_addr  = r_pc[IMEM_ADDR_W-1:0];

  assign fd_pc          = r_fd_pc;
  assign fd_ir          = r_fd_ir;
  assign fd_pred_taken  = r_fd_pred_taken;
  assign fd_pred_target = r_fd_pred_target;

  // PC register. Priority is reset, then redirect (even when stalled), then stall, then the predicted next PC.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (!stall) begin
      r_pc <= w_next_pc;
    end
  end

  // Fetch/decode latch. A redirect squashes the latch to a noop, and a stall holds it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fd_ir          <= c_noop;
      r_fd_pc          <= RESET_PC;
      r_fd_pred_taken  <= 1'b0;
      r_fd_pred_target <= '0;
    end else if (redirect_valid) begin
      r_fd_ir          <= c_noop;
      r_fd_pc          <= '0;
      r_fd_pred_taken  <= 1'b0;
      r_fd_pred_target <= '0;
    end else if (!stall) begin
      r_fd_ir          <= imem_data;
      r_fd_pc          <= w_pc_plus1;
      r_fd_pred_taken  <= w_pred_taken;
      r_fd_pred_target <= w_next_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;
  logic [31:0] r_perf_btb_hits;
  logic        w_fetch_accept;

  assign w_fetch_accept = !stall && !redirect_valid;

  assign perf_fetched   = r_perf_fetched;
  assign perf_redirects = r_perf_redirects;
  assign perf_btb_hits  = r_perf_btb_hits;

  // Saturating event counters: accepted fetches, redirects, and taken BTB hits that steered the PC.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
      r_perf_btb_hits  <= '0;
    end else begin
      if (w_fetch_accept && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (redirect_valid && (r_perf_redirects != '1))
        r_perf_redirects <= r_perf_redirects + 32'd1;
      if (w_fetch_accept && w_pred_taken && (r_perf_btb_hits != '1))
        r_perf_btb_hits <= r_perf_btb_hits + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_predict_unit.sv
// ============================================================================
//  Module   : tb_fetch_predict_unit
//  Purpose  : Self-checking bench for fetch_predict_unit (default parameters).
//             Directed scenarios and a random run are checked against a
//             behavioural model of the PC, the BTB and the fetch latch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_predict_unit;

  logic        clock = 1'b0;
  logic        reset, stall, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] fd_pc, fd_ir, fd_pred_target;
  logic        fd_pred_taken;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_redirects, perf_btb_hits;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Instruction memory: each word holds 0xA0 plus its address.
  assign imem_data = 32'hA0 + {20'd0, imem_addr};

  fetch_predict_unit dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .fd_pc          (fd_pc),
    .fd_ir          (fd_ir),
    .fd_pred_taken  (fd_pred_taken),
    .fd_pred_target (fd_pred_target)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects),
    .perf_btb_hits  (perf_btb_hits)
`endif
  );

  // Reference model state.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc, m_fd_pc, m_fd_ir, m_fd_tgt;
  logic        m_fd_pt;

  function automatic void m_lookup(input logic [31:0] pc, output logic taken,
                                   output logic [31:0] nxt);
    int unsigned idx = pc % 16;
    int unsigned tag = pc / 16;
    taken = m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
    nxt   = taken ? m_tgt[idx] : pc + 32'd1;
  endfunction

  task automatic idle();
    reset = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
  endtask

  // Advance the model by one cycle using the current inputs, then clock the DUT.
  task automatic tick();
    logic        pt;
    logic [31:0] np;
    int unsigned idx, tag;
    m_lookup(m_pc, pt, np);
    if (reset) begin
      m_pc = 0; m_fd_pc = 0; m_fd_ir = 0; m_fd_pt = 0; m_fd_tgt = 0;
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
    end else begin
      if (redirect_valid) begin
        m_fd_ir = 0; m_fd_pc = 0; m_fd_pt = 0; m_fd_tgt = 0; m_pc = redirect_pc;
      end else if (!stall) begin
        m_fd_ir = 32'hA0 + (m_pc % 4096); m_fd_pc = m_pc + 32'd1;
        m_fd_pt = pt; m_fd_tgt = np; m_pc = np;
      end
      if (upd_valid) begin
        idx = upd_pc % 16; tag = upd_pc / 16;
        if (m_valid[idx] && m_tag[idx] == tag) begin
          if (upd_taken) begin
            m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
            m_tgt[idx] = upd_target;
          end else begin
            m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
          end
        end else if (upd_taken) begin
          m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = upd_target; m_ctr[idx] = 2;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); idle();
    checks++; if (imem_addr !== 12'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", imem_addr); end
    checks++; if (fd_ir !== 32'd0) begin errors++; $display("FAIL reset_fd_ir: got %h want 0", fd_ir); end
    checks++; if (fd_pc !== 32'd0) begin errors++; $display("FAIL reset_fd_pc: got %h want 0", fd_pc); end
    checks++; if (fd_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", fd_pred_taken); end
    checks++; if (fd_pred_target !== 32'd0) begin errors++; $display("FAIL reset_pred_target: got %h want 0", fd_pred_target); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_addr !== 12'(i)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, i); end
      tick();
      checks++; if (fd_pc !== 32'(i + 1)) begin errors++; $display("FAIL seq_fd_pc[%0d]: got %h want %h", i, fd_pc, i + 1); end
      checks++; if (fd_ir !== 32'(32'hA0 + i)) begin errors++; $display("FAIL seq_fd_ir[%0d]: got %h want %h", i, fd_ir, 32'hA0 + i); end
      checks++; if (fd_pred_taken !== 1'b0) begin errors++; $display("FAIL seq_pred[%0d]: got %b want 0", i, fd_pred_taken); end
    end
  endtask

  task automatic test_btb_predict();
    idle(); upd_valid = 1; upd_pc = 5; upd_taken = 1; upd_target = 32'h40;
    redirect_valid = 1; redirect_pc = 0; tick(); idle();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (imem_addr !== 12'd5) begin errors++; $display("FAIL btb_at5: got %h want 5", imem_addr); end
    tick();
    checks++; if (imem_addr !== 12'h40) begin errors++; $display("FAIL btb_next_pc: got %h want 40", imem_addr); end
    checks++; if (fd_pred_target !== 32'h40) begin errors++; $display("FAIL btb_pred_target: got %h want 40", fd_pred_target); end
    checks++; if (fd_pred_taken !== 1'b1) begin errors++; $display("FAIL btb_pred_taken: got %b want 1", fd_pred_taken); end
    checks++; if (fd_pc !== 32'd6) begin errors++; $display("FAIL btb_fd_pc: got %h want 6", fd_pc); end
  endtask

  task automatic test_stall_redirect();
    idle(); stall = 1; redirect_valid = 1; redirect_pc = 32'h100; tick(); idle();
    checks++; if (imem_addr !== 12'h100) begin errors++; $display("FAIL sr_pc: got %h want 100", imem_addr); end
    checks++; if (fd_ir !== 32'd0) begin errors++; $display("FAIL sr_noop: got %h want 0", fd_ir); end
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 12'h101) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 101", i, imem_addr); end
      checks++; if (fd_ir !== 32'h1A0) begin errors++; $display("FAIL stall_ir[%0d]: got %h want 1a0", i, fd_ir); end
      checks++; if (fd_pc !== 32'h101) begin errors++; $display("FAIL stall_fd_pc[%0d]: got %h want 101", i, fd_pc); end
    end
    idle();
  endtask

  task automatic test_counter();
    idle(); reset = 1; tick(); idle();
    upd_valid = 1; upd_pc = 5; upd_taken = 1; upd_target = 32'h40;
    redirect_valid = 1; redirect_pc = 5; tick(); idle();
    stall = 1; upd_valid = 1; upd_pc = 5; upd_taken = 0; tick(); tick();
    idle(); tick();
    checks++; if (imem_addr !== 12'd6) begin errors++; $display("FAIL ctr_nt_pc: got %h want 6", imem_addr); end
    checks++; if (fd_pred_target !== 32'd6) begin errors++; $display("FAIL ctr_nt_target: got %h want 6", fd_pred_target); end
    redirect_valid = 1; redirect_pc = 5; upd_valid = 1; upd_pc = 5; upd_taken = 0; tick();
    idle(); stall = 1; upd_valid = 1; upd_pc = 5; upd_taken = 1; upd_target = 32'h40; tick();
    idle(); tick();
    checks++; if (imem_addr !== 12'd6) begin errors++; $display("FAIL ctr_sticky: got %h want 6", imem_addr); end
  endtask

  task automatic test_alias();
    idle(); reset = 1; tick(); idle();
    upd_valid = 1; upd_pc = 5; upd_taken = 1; upd_target = 32'h40;
    redirect_valid = 1; redirect_pc = 32'h15; tick(); idle(); tick();
    checks++; if (imem_addr !== 12'h16) begin errors++; $display("FAIL alias_miss: got %h want 16", imem_addr); end
    upd_valid = 1; upd_pc = 32'h15; upd_taken = 1; upd_target = 32'h80;
    redirect_valid = 1; redirect_pc = 5; tick(); idle(); tick();
    checks++; if (imem_addr !== 12'd6) begin errors++; $display("FAIL alias_evicted: got %h want 6", imem_addr); end
    redirect_valid = 1; redirect_pc = 32'h15; tick(); idle(); tick();
    checks++; if (imem_addr !== 12'h80) begin errors++; $display("FAIL alias_new: got %h want 80", imem_addr); end
  endtask

  task automatic test_wrap();
    idle(); reset = 1; tick(); idle();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF; tick(); idle();
    checks++; if (imem_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_addr: got %h want fff", imem_addr); end
    tick();
    checks++; if (imem_addr !== 12'd0) begin errors++; $display("FAIL wrap_pc: got %h want 0", imem_addr); end
    checks++; if (fd_pc !== 32'd0) begin errors++; $display("FAIL wrap_fd_pc: got %h want 0", fd_pc); end
    checks++; if (fd_pred_target !== 32'd0) begin errors++; $display("FAIL wrap_target: got %h want 0", fd_pred_target); end
    checks++; if (fd_ir !== 32'h109F) begin errors++; $display("FAIL wrap_fd_ir: got %h want 109f", fd_ir); end
  endtask

  task automatic test_reset_priority();
    idle(); redirect_valid = 1; redirect_pc = 32'h33; tick(); idle(); tick();
    reset = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h200;
    upd_valid = 1; upd_pc = 5; upd_taken = 1; upd_target = 32'h40; tick(); idle();
    checks++; if (imem_addr !== 12'd0) begin errors++; $display("FAIL rstprio_pc: got %h want 0", imem_addr); end
    checks++; if (fd_pc !== 32'd0 || fd_ir !== 32'd0) begin errors++; $display("FAIL rstprio_fd: got pc %h ir %h want 0 0", fd_pc, fd_ir); end
    redirect_valid = 1; redirect_pc = 5; tick(); idle(); tick();
    checks++; if (imem_addr !== 12'd6) begin errors++; $display("FAIL rstprio_no_train: got %h want 6", imem_addr); end
  endtask

  task automatic test_random();
    idle(); reset = 1; tick();
    for (int n = 0; n < 600; n++) begin
      idle();
      reset          = ($urandom_range(0, 99) < 2);
      stall          = ($urandom_range(0, 99) < 25);
      redirect_valid = ($urandom_range(0, 99) < 10);
      redirect_pc    = $urandom_range(0, 63);
      upd_valid      = ($urandom_range(0, 99) < 35);
      upd_pc         = $urandom_range(0, 63);
      upd_taken      = ($urandom_range(0, 99) < 65);
      upd_target     = $urandom_range(0, 63);
      tick();
      checks++; if (imem_addr !== m_pc[11:0]) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, imem_addr, m_pc[11:0]); end
      checks++; if (fd_pc !== m_fd_pc) begin errors++; $display("FAIL rnd_fd_pc[%0d]: got %h want %h", n, fd_pc, m_fd_pc); end
      checks++; if (fd_ir !== m_fd_ir) begin errors++; $display("FAIL rnd_fd_ir[%0d]: got %h want %h", n, fd_ir, m_fd_ir); end
      checks++; if (fd_pred_taken !== m_fd_pt) begin errors++; $display("FAIL rnd_pred[%0d]: got %b want %b", n, fd_pred_taken, m_fd_pt); end
      checks++; if (fd_pred_target !== m_fd_tgt) begin errors++; $display("FAIL rnd_target[%0d]: got %h want %h", n, fd_pred_target, m_fd_tgt); end
    end
    idle();
  endtask

  initial begin
    idle();
    m_pc = 0; m_fd_pc = 0; m_fd_ir = 0; m_fd_pt = 0; m_fd_tgt = 0;
    test_reset();
    test_sequential();
    test_btb_predict();
    test_stall_redirect();
    test_counter();
    test_alias();
    test_wrap();
    test_reset_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
